// File: rtl/seq_mantissa_mul.sv
// Sequential radix-2 shift-add mantissa multiplier: (1.Xm)*(1.Ym) normalised to 1.f form.
// Build option ROUND_RNE_EN: round the fraction to nearest-even instead of truncating it.
module seq_mantissa_mul #(
   parameter int MW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] Xm,
   input  logic [MW-1:0] Ym,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW-1:0] Zm,
   output logic          PM,
   output logic [1:0]    exp_inc,
   output logic [1:0]    dbg_state
);

   // Handshake: a transfer happens at a posedge where valid && ready are both high.
   // in_ready is high only in IDLE outside reset; out_valid holds a stable payload until out_ready.

   localparam int PW = 2 * (MW + 1);
   localparam int CW = $clog2(MW + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] mcand;
   logic [PW-1:0] acc;
   logic [MW:0]   mplier;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last_bit;
   logic [PW-2:0] sh;
   logic [MW-1:0] zm_nxt;
   logic [1:0]    inc_nxt;

   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt == CW'(MW));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = S_MUL;
         S_MUL:   if (last_bit)  state_nxt = S_NORM;
         S_NORM:                 state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && (state == S_IDLE);
      out_valid = (state == S_DONE);
      dbg_state = state;
   end

   // Multiplicand shifts left while the multiplier shifts right, LSB first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         Zm      <= '0;
         PM      <= 1'b0;
         exp_inc <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mcand  <= {{(MW+1){1'b0}}, 1'b1, Xm};
                  mplier <= {1'b1, Ym};
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            S_MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= last_bit ? '0 : cnt + CW'(1);
            end
            S_NORM: begin
               Zm      <= zm_nxt;
               PM      <= acc[PW-1];
               exp_inc <= inc_nxt;
            end
            default: ;
         endcase
      end
   end

   // Align the product so the leading one sits just above bit PW-2.
   assign sh = acc[PW-1] ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};

`ifdef ROUND_RNE_EN
   logic        guard;
   logic        sticky;
   logic        rnd_up;
   logic [MW:0] zm_sum;

   // A carry out of an all-ones fraction leaves zero and bumps the exponent once more.
   always_comb begin
      guard   = sh[MW];
      sticky  = |sh[MW-1:0];
      rnd_up  = guard & (sticky | sh[MW+1]);
      zm_sum  = {1'b0, sh[PW-2:MW+1]} + {{MW{1'b0}}, rnd_up};
      zm_nxt  = zm_sum[MW-1:0];
      inc_nxt = {1'b0, acc[PW-1]} + {1'b0, zm_sum[MW]};
   end
`else
   logic unused_low;

   assign zm_nxt     = sh[PW-2:MW+1];
   assign inc_nxt    = {1'b0, acc[PW-1]};
   assign unused_low = ^sh[MW:0];
`endif

endmodule

// File: tb/tb_seq_mantissa_mul.sv
// Directed bench for seq_mantissa_mul (MW=7): reset, vector table, handshake stall,
// back-to-back throughput and reset abort; expectations follow ROUND_RNE_EN.
module tb_seq_mantissa_mul;

   localparam int MW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [MW-1:0] Xm = '0;
   logic [MW-1:0] Ym = '0;
   logic          in_ready;
   logic          out_valid;
   logic [MW-1:0] Zm;
   logic          PM;
   logic [1:0]    exp_inc;
   logic [1:0]    dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   seq_mantissa_mul #(.MW(MW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xm        (Xm),
      .Ym        (Ym),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Zm        (Zm),
      .PM        (PM),
      .exp_inc   (exp_inc),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, want finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one operand pair, then waits for the result; lat counts the acceptance edge as 1.
   task automatic do_op(input logic [MW-1:0] x, input logic [MW-1:0] y,
                        output int lat, output int acc_cyc,
                        output logic [MW-1:0] zm, output logic pm, output logic [1:0] inc);
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      in_valid = 1'b1;
      Xm = x;
      Ym = y;
      tick();
      acc_cyc = cyc;
      in_valid = 1'b0;
      Xm = MW'($urandom_range(0, 127));
      Ym = MW'($urandom_range(0, 127));
      lat = 1;
      for (int i = 0; i < 30 && !out_valid; i++) begin
         tick();
         lat++;
      end
      zm  = Zm;
      pm  = PM;
      inc = exp_inc;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({in_ready, out_valid, Zm, PM, exp_inc} !== {1'b0, 1'b0, 7'h00, 1'b0, 2'd0}) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b zm=%h pm=%b inc=%0d want 0 0 00 0 0",
                  in_ready, out_valid, Zm, PM, exp_inc);
      end
      rst_n = 1'b1;
      tick();
      n_vec++;
      if ({in_ready, dbg_state} !== {1'b1, 2'd0}) begin
         n_err++;
         $display("FAIL reset_release: got rdy=%b st=%0d want rdy=1 st=0", in_ready, dbg_state);
      end
   endtask

   task automatic test_vectors();
      logic [MW-1:0] vx [9];
      logic [MW-1:0] vy [9];
      logic [MW-1:0] ez [9];
      logic          ep [9];
      logic [1:0]    ei [9];
      int            lat;
      int            ac;
      logic [MW-1:0] zm;
      logic          pm;
      logic [1:0]    inc;
      vx = '{7'h00, 7'h40, 7'h7F, 7'h40, 7'h35, 7'h7F, 7'h00, 7'h7F, 7'h01};
      vy = '{7'h00, 7'h40, 7'h7F, 7'h01, 7'h35, 7'h00, 7'h40, 7'h01, 7'h01};
`ifdef ROUND_RNE_EN
      ez = '{7'h00, 7'h10, 7'h7E, 7'h42, 7'h00, 7'h7F, 7'h40, 7'h00, 7'h02};
      ei = '{2'd0,  2'd1,  2'd1,  2'd0,  2'd1,  2'd0,  2'd0,  2'd1,  2'd0};
`else
      ez = '{7'h00, 7'h10, 7'h7E, 7'h41, 7'h7F, 7'h7F, 7'h40, 7'h00, 7'h02};
      ei = '{2'd0,  2'd1,  2'd1,  2'd0,  2'd0,  2'd0,  2'd0,  2'd1,  2'd0};
`endif
      ep = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
      for (int i = 0; i < 9; i++) begin
         do_op(vx[i], vy[i], lat, ac, zm, pm, inc);
         n_vec++;
         if (lat !== MW + 3) begin
            n_err++;
            $display("FAIL vec%0d latency: got %0d want %0d", i, lat, MW + 3);
         end
         n_vec++;
         if ({zm, pm, inc} !== {ez[i], ep[i], ei[i]}) begin
            n_err++;
            $display("FAIL vec%0d result %h*%h: got zm=%h pm=%b inc=%0d want zm=%h pm=%b inc=%0d",
                     i, vx[i], vy[i], zm, pm, inc, ez[i], ep[i], ei[i]);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         n_vec++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL vec%0d release: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_handshake();
      int            lat;
      int            ac;
      logic [MW-1:0] zm;
      logic          pm;
      logic [1:0]    inc;
      do_op(7'h40, 7'h40, lat, ac, zm, pm, inc);
      in_valid = 1'b1;
      Xm = 7'h7F;
      Ym = 7'h7F;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if ({out_valid, in_ready, Zm, PM, exp_inc} !== {1'b1, 1'b0, 7'h10, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL stall%0d: got vld=%b rdy=%b zm=%h pm=%b inc=%0d want 1 0 10 1 1",
                     i, out_valid, in_ready, Zm, PM, exp_inc);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL stall_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      tick();
      tick();
      tick();
      n_vec++;
      if ({out_valid, dbg_state} !== {1'b0, 2'd0}) begin
         n_err++;
         $display("FAIL stall_ignored_input: got vld=%b st=%0d want vld=0 st=0", out_valid, dbg_state);
      end
   endtask

   task automatic test_back_to_back();
      int            lat;
      int            ac1;
      int            ac2;
      logic [MW-1:0] zm;
      logic          pm;
      logic [1:0]    inc;
      do_op(7'h00, 7'h40, lat, ac1, zm, pm, inc);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      do_op(7'h7F, 7'h7F, lat, ac2, zm, pm, inc);
      n_vec++;
      if (ac2 - ac1 !== MW + 4) begin
         n_err++;
         $display("FAIL b2b_interval: got %0d want %0d", ac2 - ac1, MW + 4);
      end
      n_vec++;
      if ({zm, pm, inc} !== {7'h7E, 1'b1, 2'd1}) begin
         n_err++;
         $display("FAIL b2b_result: got zm=%h pm=%b inc=%0d want zm=7e pm=1 inc=1", zm, pm, inc);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      int            lat;
      int            ac;
      logic [MW-1:0] zm;
      logic          pm;
      logic [1:0]    inc;
      logic          seen;
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      in_valid = 1'b1;
      Xm = 7'h7F;
      Ym = 7'h7F;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      n_vec++;
      if (dbg_state !== 2'd1) begin
         n_err++;
         $display("FAIL abort_in_mul: got st=%0d want st=1", dbg_state);
      end
      rst_n = 1'b0;
      tick();
      n_vec++;
      if ({out_valid, in_ready, Zm, PM, exp_inc, dbg_state} !== {1'b0, 1'b0, 7'h00, 1'b0, 2'd0, 2'd0}) begin
         n_err++;
         $display("FAIL abort_reset: got vld=%b rdy=%b zm=%h pm=%b inc=%0d st=%0d want 0 0 00 0 0 0",
                  out_valid, in_ready, Zm, PM, exp_inc, dbg_state);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_result: got out_valid seen=%b want 0", seen);
      end
      do_op(7'h40, 7'h40, lat, ac, zm, pm, inc);
      n_vec++;
      if ({lat, zm, pm, inc} !== {MW + 3, 7'h10, 1'b1, 2'd1}) begin
         n_err++;
         $display("FAIL abort_next_op: got lat=%0d zm=%h pm=%b inc=%0d want lat=%0d zm=10 pm=1 inc=1",
                  lat, zm, pm, inc, MW + 3);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_vectors();
      test_handshake();
      test_back_to_back();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
